// File: rtl/ewa_share_arb.sv
// rtl/ewa_share_arb.sv - round-robin burst arbiter sharing one element-wise adder engine
// Grants the engine per burst and tags each issued tile so results route back in issue order.
module ewa_share_arb #(
   parameter int NREQ      = 2,
   parameter int TILE_SIZE = 4,
   parameter int W         = 16,
   parameter int TAG_DEPTH = 4,
   parameter int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NREQ-1:0]                      req_valid,
   input  logic [NREQ-1:0]                      req_last,
   input  logic [NREQ-1:0][TILE_SIZE-1:0][W-1:0] req_a,
   input  logic [NREQ-1:0][TILE_SIZE-1:0][W-1:0] req_b,
   output logic [NREQ-1:0]                      req_ready,
   output logic [NREQ-1:0]                      rsp_valid,
   input  logic [NREQ-1:0]                      rsp_ready,
   output logic [TILE_SIZE-1:0][W-1:0]          rsp_y,
   output logic                                 eng_in_valid,
   input  logic                                 eng_in_ready,
   output logic [TILE_SIZE-1:0][W-1:0]          eng_a,
   output logic [TILE_SIZE-1:0][W-1:0]          eng_b,
   input  logic                                 eng_out_valid,
   output logic                                 eng_out_ready,
   input  logic [TILE_SIZE-1:0][W-1:0]          eng_y,
   output logic                                 busy,
   output logic [IDW-1:0]                       cur_grant,
   output logic                                 err_orphan
);
   localparam int PW = $clog2(TAG_DEPTH);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] grant_id, grant_nxt;
   logic [IDW-1:0] rr_ptr, rr_nxt;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] head;
   logic [IDW-1:0] tag_mem [TAG_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [PW:0]    count;
   logic           any_req, not_full, has_tag, push, pop;

   assign not_full  = count < (PW+1)'(TAG_DEPTH);
   assign has_tag   = count != '0;
   assign head      = tag_mem[rd_ptr];
   assign busy      = (state == S_GRANT) || has_tag;
   assign cur_grant = grant_id;
   assign eng_a     = req_a[grant_id];
   assign eng_b     = req_b[grant_id];
   assign rsp_y     = eng_y;

   // Scan from the highest offset down so the requester nearest rr_ptr wins.
   always_comb begin
      int             idx;
      logic [IDW-1:0] idx_c;
      winner  = rr_ptr;
      any_req = 1'b0;
      idx     = 0;
      idx_c   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx   = (int'(rr_ptr) + i) % NREQ;
         idx_c = IDW'(idx);
         if (req_valid[idx_c]) begin
            winner  = idx_c;
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant_id;
      rr_nxt       = rr_ptr;
      req_ready    = '0;
      eng_in_valid = 1'b0;
      push         = 1'b0;
      case (state)
         S_IDLE: begin
            if (any_req) begin
               grant_nxt = winner;
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            eng_in_valid        = req_valid[grant_id] && not_full;
            req_ready[grant_id] = eng_in_ready && not_full;
            push                = eng_in_valid && eng_in_ready;
            if (push && req_last[grant_id]) begin
               rr_nxt    = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         rr_ptr   <= rr_nxt;
      end
   end

   // Results with no outstanding tag are never acknowledged.
   always_comb begin
      rsp_valid = '0;
      if (eng_out_valid && has_tag) rsp_valid[head] = 1'b1;
   end

   assign eng_out_ready = has_tag && rsp_ready[head];
   assign pop           = eng_out_valid && eng_out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         err_orphan <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (eng_out_valid && !has_tag) err_orphan <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= grant_id;
   end

endmodule

// File: tb/tb_ewa_share_arb.sv
// tb/tb_ewa_share_arb.sv - self-checking bench for ewa_share_arb
// Bench models requesters and a 1-cycle adder engine; vectors carry hand-computed results.
`timescale 1ns/1ps
module tb_ewa_share_arb;
   localparam int NREQ      = 2;
   localparam int TILE_SIZE = 4;
   localparam int W         = 16;
   localparam int TAG_DEPTH = 4;
   localparam int IDW       = 1;

   typedef logic [TILE_SIZE-1:0][W-1:0] tile_t;
   typedef struct {
      tile_t a;
      tile_t b;
      logic  last;
   } req_tile_t;
   typedef struct {
      int    rid;
      int    ntiles;
      tile_t a;
      tile_t b;
      tile_t y;
   } vec_t;

   logic                                 clk = 1'b0;
   logic                                 rst = 1'b1;
   logic [NREQ-1:0]                      req_valid = '0;
   logic [NREQ-1:0]                      req_last = '0;
   logic [NREQ-1:0][TILE_SIZE-1:0][W-1:0] req_a = '0;
   logic [NREQ-1:0][TILE_SIZE-1:0][W-1:0] req_b = '0;
   logic [NREQ-1:0]                      req_ready;
   logic [NREQ-1:0]                      rsp_valid;
   logic [NREQ-1:0]                      rsp_ready = '0;
   tile_t                                rsp_y;
   logic                                 eng_in_valid;
   logic                                 eng_in_ready = 1'b0;
   tile_t                                eng_a, eng_b;
   logic                                 eng_out_valid = 1'b0;
   logic                                 eng_out_ready;
   tile_t                                eng_y = '0;
   logic                                 busy;
   logic [IDW-1:0]                       cur_grant;
   logic                                 err_orphan;

   always #5 clk = ~clk;

   ewa_share_arb #(
      .NREQ(NREQ), .TILE_SIZE(TILE_SIZE), .W(W), .TAG_DEPTH(TAG_DEPTH), .IDW(IDW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
      .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready),
      .eng_a(eng_a), .eng_b(eng_b),
      .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready), .eng_y(eng_y),
      .busy(busy), .cur_grant(cur_grant), .err_orphan(err_orphan)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   req_tile_t       send_q [NREQ][$];
   tile_t           exp_q  [NREQ][$];
   tile_t           eng_q  [$];
   logic [NREQ-1:0] req_en, rsp_rdy;
   logic            eng_in_rdy, eng_out_en, force_orphan;
   int              issue_rid [$];
   int              issue_cyc [$];
   int              rsp_rid   [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic tile_t mk(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                input logic [W-1:0] x2, input logic [W-1:0] x3);
      tile_t t;
      t[0] = x0; t[1] = x1; t[2] = x2; t[3] = x3;
      return t;
   endfunction

   function automatic tile_t add_t(input tile_t a, input tile_t b);
      tile_t t;
      for (int l = 0; l < TILE_SIZE; l++) t[l] = a[l] + b[l];
      return t;
   endfunction

   task automatic clear_logs();
      issue_rid.delete();
      issue_cyc.delete();
      rsp_rid.delete();
   endtask

   task automatic flush();
      for (int i = 0; i < NREQ; i++) begin
         send_q[i].delete();
         exp_q[i].delete();
      end
      eng_q.delete();
      clear_logs();
      req_en       = '1;
      rsp_rdy      = '1;
      eng_in_rdy   = 1'b1;
      eng_out_en   = 1'b1;
      force_orphan = 1'b0;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         if (send_q[i].size() > 0) begin
            req_valid[i] = req_en[i];
            req_last[i]  = send_q[i][0].last;
            req_a[i]     = send_q[i][0].a;
            req_b[i]     = send_q[i][0].b;
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
            req_a[i]     = '0;
            req_b[i]     = '0;
         end
      end
      rsp_ready     = rsp_rdy;
      eng_in_ready  = eng_in_rdy;
      eng_out_valid = force_orphan || (eng_out_en && eng_q.size() > 0);
      eng_y         = (eng_q.size() > 0) ? eng_q[0] : '0;
   endtask

   task automatic observe();
      cyc++;
      chk("req_ready_onehot", 64'($onehot0(req_ready)), 64'(1));
      chk("issue_consistent", 64'(eng_in_valid && eng_in_ready), 64'(|(req_valid & req_ready)));
      chk("return_consistent", 64'(eng_out_valid && eng_out_ready), 64'(|(rsp_valid & rsp_ready)));
      if (eng_out_valid && eng_out_ready && eng_q.size() > 0) void'(eng_q.pop_front());
      for (int i = 0; i < NREQ; i++) begin
         if (rsp_valid[i]) begin
            chk("rsp_pending", 64'(exp_q[i].size() > 0), 64'(1));
            if (rsp_ready[i] && exp_q[i].size() > 0) begin
               chk("rsp_y", 64'(rsp_y), 64'(exp_q[i][0]));
               void'(exp_q[i].pop_front());
               rsp_rid.push_back(i);
            end
         end
         if (req_valid[i] && req_ready[i]) begin
            chk("eng_a", 64'(eng_a), 64'(send_q[i][0].a));
            chk("eng_b", 64'(eng_b), 64'(send_q[i][0].b));
            eng_q.push_back(add_t(eng_a, eng_b));
            void'(send_q[i].pop_front());
            issue_rid.push_back(i);
            issue_cyc.push_back(cyc);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      drive();
      #1;
      observe();
   endtask

   function automatic bit idle_now();
      bit e;
      e = (eng_q.size() == 0) && !busy;
      for (int i = 0; i < NREQ; i++) e = e && (send_q[i].size() == 0) && (exp_q[i].size() == 0);
      return e;
   endfunction

   task automatic run_until_idle(input int max_cyc);
      bit done;
      done = 1'b0;
      for (int k = 0; k < max_cyc && !done; k++) begin
         step();
         done = idle_now();
      end
      chk("drain_timeout", 64'(done), 64'(1));
   endtask

   task automatic add_burst(input int rid, input int n, input int base);
      req_tile_t t;
      for (int k = 0; k < n; k++) begin
         for (int l = 0; l < TILE_SIZE; l++) begin
            t.a[l] = W'(base + 16 * k + l);
            t.b[l] = W'(1000 + 7 * k + 3 * l + rid);
         end
         t.last = (k == n - 1);
         send_q[rid].push_back(t);
         exp_q[rid].push_back(add_t(t.a, t.b));
      end
   endtask

   task automatic reset_dut();
      flush();
      rst = 1'b1;
      drive();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   vec_t      vec [4];
   req_tile_t rt;
   int        cont_rid [8];
   int        cont_cyc [8];
   int        il_rid   [4];

   initial begin
      vec[0] = '{0, 3, mk(1, 2, 3, 4), mk(10, 20, 30, 40), mk(11, 22, 33, 44)};
      vec[1] = '{1, 1, mk(100, 200, 300, 400), mk(5, 6, 7, 8), mk(105, 206, 307, 408)};
      vec[2] = '{0, 2, mk(16'hFFFF, 0, 1, 2), mk(1, 0, 1, 2), mk(0, 0, 2, 4)};
      vec[3] = '{1, 2, mk(16'h8000, 16'h7FFF, 50, 60), mk(16'h8000, 1, 50, 60), mk(0, 16'h8000, 100, 120)};
      cont_rid = '{0, 0, 1, 1, 0, 0, 1, 1};
      cont_cyc = '{2, 3, 5, 6, 8, 9, 11, 12};
      il_rid   = '{0, 0, 1, 1};

      reset_dut();
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_eng_in_valid", 64'(eng_in_valid), 64'(0));
      chk("rst_eng_out_ready", 64'(eng_out_ready), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_cur_grant", 64'(cur_grant), 64'(0));
      chk("rst_err_orphan", 64'(err_orphan), 64'(0));

      for (int v = 0; v < 4; v++) begin
         clear_logs();
         for (int k = 0; k < vec[v].ntiles; k++) begin
            rt.a    = vec[v].a;
            rt.b    = vec[v].b;
            rt.last = (k == vec[v].ntiles - 1);
            send_q[vec[v].rid].push_back(rt);
            exp_q[vec[v].rid].push_back(vec[v].y);
         end
         run_until_idle(200);
         chk("tbl_grant", 64'(cur_grant), 64'(vec[v].rid));
         chk("tbl_issue_count", 64'(issue_rid.size()), 64'(vec[v].ntiles));
         chk("tbl_rsp_count", 64'(rsp_rid.size()), 64'(vec[v].ntiles));
      end

      // Two 2-tile bursts per requester, both valid from reset.
      reset_dut();
      add_burst(0, 2, 16'h0100);
      add_burst(0, 2, 16'h0200);
      add_burst(1, 2, 16'h0300);
      add_burst(1, 2, 16'h0400);
      run_until_idle(200);
      chk("cont_issue_count", 64'(issue_rid.size()), 64'(8));
      if (issue_rid.size() == 8) begin
         for (int k = 0; k < 8; k++) begin
            chk("cont_order", 64'(issue_rid[k]), 64'(cont_rid[k]));
            chk("cont_cycle", 64'(issue_cyc[k]), 64'(cont_cyc[k]));
         end
      end

      // Response backpressure fills the tag FIFO.
      reset_dut();
      add_burst(0, 6, 16'h0500);
      rsp_rdy = 2'b10;
      repeat (10) step();
      chk("bp_issued", 64'(issue_rid.size()), 64'(4));
      chk("bp_ready_low", 64'(req_ready[0]), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
      chk("bp_no_rsp", 64'(rsp_rid.size()), 64'(0));
      rsp_rdy = 2'b11;
      step();
      chk("bp_full_blocks_on_pop", 64'(req_ready[0]), 64'(0));
      chk("bp_first_pop", 64'(rsp_rid.size()), 64'(1));
      run_until_idle(100);
      chk("bp_issued_all", 64'(issue_rid.size()), 64'(6));
      chk("bp_rsp_all", 64'(rsp_rid.size()), 64'(6));

      // Engine output held, then released with requester 1 not ready.
      reset_dut();
      add_burst(0, 2, 16'h0600);
      add_burst(1, 2, 16'h0700);
      eng_out_en = 1'b0;
      rsp_rdy    = 2'b01;
      repeat (8) step();
      chk("il_issued", 64'(issue_rid.size()), 64'(4));
      chk("il_no_rsp", 64'(rsp_rid.size()), 64'(0));
      eng_out_en = 1'b1;
      repeat (4) step();
      chk("il_partial", 64'(rsp_rid.size()), 64'(2));
      chk("il_stall_valid", 64'(rsp_valid), 64'(2'b10));
      chk("il_stall_ready", 64'(eng_out_ready), 64'(0));
      rsp_rdy = 2'b11;
      run_until_idle(50);
      chk("il_rsp_count", 64'(rsp_rid.size()), 64'(4));
      if (rsp_rid.size() == 4) begin
         for (int k = 0; k < 4; k++) chk("il_order", 64'(rsp_rid[k]), 64'(il_rid[k]));
      end

      // Result with no tag outstanding.
      clear_logs();
      force_orphan = 1'b1;
      step();
      chk("orph_ready", 64'(eng_out_ready), 64'(0));
      chk("orph_rsp", 64'(rsp_valid), 64'(0));
      chk("orph_not_yet", 64'(err_orphan), 64'(0));
      force_orphan = 1'b0;
      step();
      chk("orph_set", 64'(err_orphan), 64'(1));
      repeat (3) step();
      chk("orph_sticky", 64'(err_orphan), 64'(1));
      chk("orph_idle", 64'(busy), 64'(0));

      // Asynchronous reset with two tiles in flight.
      clear_logs();
      add_burst(0, 4, 16'h0800);
      eng_out_en = 1'b0;
      repeat (3) step();
      @(posedge clk);
      #2;
      chk("rm_pre_issued", 64'(issue_rid.size()), 64'(2));
      chk("rm_pre_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      #1;
      chk("rm_busy", 64'(busy), 64'(0));
      chk("rm_err_orphan", 64'(err_orphan), 64'(0));
      chk("rm_eng_in_valid", 64'(eng_in_valid), 64'(0));
      chk("rm_req_ready", 64'(req_ready), 64'(0));
      chk("rm_cur_grant", 64'(cur_grant), 64'(0));
      flush();
      drive();
      @(negedge clk);
      #1;
      chk("rm_busy_after_edge", 64'(busy), 64'(0));
      rst = 1'b0;
      cyc = 0;
      add_burst(1, 2, 16'h0900);
      run_until_idle(50);
      chk("rm_new_rsp", 64'(rsp_rid.size()), 64'(2));
      chk("rm_new_grant", 64'(cur_grant), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
